// File: rtl/serial_adder_if.sv
// Request/result handshake bundle for serial_adder.
// SERIAL_ADDER_SUB_EN adds the sub request bit and the ovf result bit.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
    logic             ovf;

    modport master (
        output start_valid, a, b, cin, sub, res_ready,
        input  start_ready, res_valid, sum, cout, busy, ovf
    );
    modport slave (
        input  start_valid, a, b, cin, sub, res_ready,
        output start_ready, res_valid, sum, cout, busy, ovf
    );
`else
    modport master (
        output start_valid, a, b, cin, res_ready,
        input  start_ready, res_valid, sum, cout, busy
    );
    modport slave (
        input  start_valid, a, b, cin, res_ready,
        output start_ready, res_valid, sum, cout, busy
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a+b+cin, DIGIT bits per clock, LSB digit first.
// Optional subtract/overflow support is enabled with SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   sum_r;
    logic               carry_r;
    logic               cout_r;
    logic [CNT_W-1:0]   count_r;
    logic               start_ready_r;
    logic               res_valid_r;
    logic               busy_r;
    logic [DIGIT:0]     dig_s;
    logic [WIDTH+DIGIT-1:0] cat_s;
`ifdef SERIAL_ADDER_SUB_EN
    logic               ovf_r;
    logic               cmsb_s;
`endif

    // Propagate/generate ripple over one digit; returns {carry_out, sum_bits}.
    function automatic logic [DIGIT:0] digit_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             c
    );
        logic [DIGIT:0]   cy;
        logic [DIGIT-1:0] s;
        logic             p;
        logic             g;
        cy[0] = c;
        for (int i = 0; i < DIGIT; i++) begin
            p       = x[i] ^ y[i];
            g       = x[i] & y[i];
            s[i]    = p ^ cy[i];
            cy[i+1] = g | (p & cy[i]);
        end
        return {cy[DIGIT], s};
    endfunction

    // Current digit result and the sum register after shifting it in from the top.
    always_comb begin
        dig_s = digit_add(a_r[DIGIT-1:0], b_r[DIGIT-1:0], carry_r);
        cat_s = {dig_s[DIGIT-1:0], sum_r};
    end

`ifdef SERIAL_ADDER_SUB_EN
    // Carry into the top bit recovered from the top sum bit and its operand bits.
    always_comb begin
        cmsb_s = dig_s[DIGIT-1] ^ a_r[DIGIT-1] ^ b_r[DIGIT-1];
    end
`endif

    // Control FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            a_r           <= {WIDTH{1'b0}};
            b_r           <= {WIDTH{1'b0}};
            sum_r         <= {WIDTH{1'b0}};
            carry_r       <= 1'b0;
            cout_r        <= 1'b0;
            count_r       <= {CNT_W{1'b0}};
            start_ready_r <= 1'b1;
            res_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_r         <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_r           <= bus.a;
`ifdef SERIAL_ADDER_SUB_EN
                        b_r           <= bus.sub ? ~bus.b : bus.b;
                        carry_r       <= bus.sub | bus.cin;
`else
                        b_r           <= bus.b;
                        carry_r       <= bus.cin;
`endif
                        count_r       <= {CNT_W{1'b0}};
                        start_ready_r <= 1'b0;
                        busy_r        <= 1'b1;
                        state_r       <= RUN;
                    end else begin
                        state_r       <= IDLE;
                    end
                end
                RUN: begin
                    sum_r   <= cat_s[WIDTH+DIGIT-1:DIGIT];
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    carry_r <= dig_s[DIGIT];
                    count_r <= count_r + CNT_W'(1);
                    if (count_r == CNT_W'(N - 1)) begin
                        cout_r      <= dig_s[DIGIT];
`ifdef SERIAL_ADDER_SUB_EN
                        ovf_r       <= dig_s[DIGIT] ^ cmsb_s;
`endif
                        res_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        state_r     <= RUN;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_r   <= 1'b0;
                        busy_r        <= 1'b0;
                        start_ready_r <= 1'b1;
                        state_r       <= IDLE;
                    end else begin
                        state_r       <= DONE;
                    end
                end
                default: begin
                    res_valid_r   <= 1'b0;
                    busy_r        <= 1'b0;
                    start_ready_r <= 1'b1;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.busy        = busy_r;
    assign bus.sum         = sum_r;
    assign bus.cout        = cout_r;
`ifdef SERIAL_ADDER_SUB_EN
    assign bus.ovf         = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomised bench for serial_adder: three configurations (8/1, 8/4, 1/1) driven in lockstep
// and compared against plain-arithmetic results.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sv;
    logic       rr;
    logic [7:0] da;
    logic [7:0] db;
    logic       dc;
    int         checks = 0;
    int         errors = 0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       ds;
`endif

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if81 ();
    serial_adder_if #(.WIDTH(8)) if84 ();
    serial_adder_if #(.WIDTH(1)) if11 ();

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_81 (.clk(clk), .rst_n(rst_n), .bus(if81));
    serial_adder #(.WIDTH(8), .DIGIT(4)) u_84 (.clk(clk), .rst_n(rst_n), .bus(if84));
    serial_adder #(.WIDTH(1), .DIGIT(1)) u_11 (.clk(clk), .rst_n(rst_n), .bus(if11));

    assign if81.start_valid = sv;  assign if84.start_valid = sv;  assign if11.start_valid = sv;
    assign if81.res_ready   = rr;  assign if84.res_ready   = rr;  assign if11.res_ready   = rr;
    assign if81.a   = da;          assign if84.a   = da;          assign if11.a   = da[0];
    assign if81.b   = db;          assign if84.b   = db;          assign if11.b   = db[0];
    assign if81.cin = dc;          assign if84.cin = dc;          assign if11.cin = dc;
`ifdef SERIAL_ADDER_SUB_EN
    assign if81.sub = ds;          assign if84.sub = ds;          assign if11.sub = ds;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One operation on all three instances: accept, measure latency, optional backpressure, take.
    task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                         input logic xs, input int hold);
        logic [7:0] be;
        logic       ce;
        logic [8:0] r8;
        logic [1:0] r1;
        logic       of;
        int         l81, l84, l11;
        be = xs ? ~xb : xb;
        ce = xs ? 1'b1 : xc;
        r8 = {1'b0, xa} + {1'b0, be} + {8'd0, ce};
        r1 = {1'b0, xa[0]} + {1'b0, be[0]} + {1'b0, ce};
        of = (xa[7] == be[7]) && (r8[7] != xa[7]);
        l81 = -1; l84 = -1; l11 = -1;

        @(negedge clk);
        check("idle_ready", 32'({if81.start_ready, if84.start_ready, if11.start_ready}), 32'd7);
        sv = 1'b1; rr = 1'b0; da = xa; db = xb; dc = xc;
`ifdef SERIAL_ADDER_SUB_EN
        ds = xs;
`endif
        for (int cyc = 0; cyc <= 40; cyc++) begin
            @(negedge clk);
            sv = 1'($urandom_range(0, 1));
            da = 8'($urandom);
            db = 8'($urandom);
            dc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
            ds = 1'($urandom_range(0, 1));
`endif
            if (l81 < 0 && if81.res_valid) l81 = cyc;
            if (l84 < 0 && if84.res_valid) l84 = cyc;
            if (l11 < 0 && if11.res_valid) l11 = cyc;
            if (l81 >= 0 && l84 >= 0 && l11 >= 0) break;
        end
        check("lat_8x1", 32'(l81), 32'd8);
        check("lat_8x4", 32'(l84), 32'd2);
        check("lat_1x1", 32'(l11), 32'd1);

        sv = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("bp_valid", 32'({if81.res_valid, if84.res_valid, if11.res_valid}), 32'd7);
            check("bp_ready", 32'({if81.start_ready, if84.start_ready, if11.start_ready}), 32'd0);
            check("bp_sum", 32'({if81.cout, if81.sum}), 32'(r8));
        end

        check("sum_8x1", 32'({if81.cout, if81.sum}), 32'(r8));
        check("sum_8x4", 32'({if84.cout, if84.sum}), 32'(r8));
        check("sum_1x1", 32'({if11.cout, if11.sum}), 32'(r1));
        check("busy_done", 32'({if81.busy, if84.busy, if11.busy}), 32'd7);
`ifdef SERIAL_ADDER_SUB_EN
        check("ovf_8x1", 32'(if81.ovf), 32'(of));
        check("ovf_8x4", 32'(if84.ovf), 32'(of));
`else
        if (of === 1'bx) $display("unexpected unknown in model");
`endif

        sv = 1'b0; rr = 1'b1;
        @(negedge clk);
        check("take_valid", 32'({if81.res_valid, if84.res_valid, if11.res_valid}), 32'd0);
        check("take_ready", 32'({if81.start_ready, if84.start_ready, if11.start_ready}), 32'd7);
        check("take_hold", 32'({if81.cout, if81.sum}), 32'(r8));
        rr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       any_valid;
        rst_n = 1'b0; sv = 1'b0; rr = 1'b0; da = 8'd0; db = 8'd0; dc = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        ds = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_outs", 32'({if81.res_valid, if81.busy, if81.cout, if81.sum}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'({if81.start_ready, if84.start_ready, if11.start_ready}), 32'd7);
        check("rst_busy", 32'({if81.busy, if84.busy, if11.busy}), 32'd0);

        do_op(8'h5A, 8'hA5, 1'b1, 1'b0, 0);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 0);
        do_op(8'hC3, 8'h3C, 1'b1, 1'b0, 5);

        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op({ra[7:1], i[2]}, {rb[7:1], i[1]}, i[0], 1'b0, 0);
        end

        for (int i = 0; i < 12; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0,
                  int'($urandom_range(0, 2)));
        end

`ifdef SERIAL_ADDER_SUB_EN
        do_op(8'h03, 8'h05, 1'b0, 1'b1, 0);
        do_op(8'h80, 8'h01, 1'b1, 1'b1, 0);
        for (int i = 0; i < 8; i++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 0);
        end
`endif

        // Abort an operation in the middle of its RUN phase.
        @(negedge clk);
        sv = 1'b1; da = 8'h77; db = 8'h11; dc = 1'b0;
        @(negedge clk);
        sv = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(if81.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_outs", 32'({if81.res_valid, if81.busy, if81.cout, if81.sum}), 32'd0);
        check("mid_rst_busy", 32'({if84.busy, if11.busy, if84.res_valid, if11.res_valid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            any_valid = any_valid | if81.res_valid;
        end
        check("mid_no_valid", 32'(any_valid), 32'd0);
        check("mid_ready", 32'({if81.start_ready, if81.busy}), 32'd2);
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle successor to the single-cycle full adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, LSB digit first.
- The per-cycle datapath is a DIGIT-bit propagate/generate ripple chain (p=a^b, g=a&b, s=p^c, c'=g|(p&c)) with a registered carry between digits.
- Sits behind a valid/ready request port and a valid/ready result port, so arithmetic units can trade area for latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be at least 1.
- DIGIT, 1, bits added per cycle; WIDTH mod DIGIT must be 0 (elaboration error otherwise).
- Derived: N = WIDTH/DIGIT, the number of RUN cycles per operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request valid.
- start_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A; sampled on the accept edge only.
- b  in  WIDTH  operand B; sampled on the accept edge only.
- cin  in  1  carry-in; sampled on the accept edge only.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result bits, registered.
- cout  out  1  carry out of bit WIDTH-1, registered.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - Operand shift registers, carry register, digit counter, sum and cout all cleared to 0.
  - start_ready=1, res_valid=0, busy=0 once reset is released.
- States:
  - IDLE: start_ready=1. On start_valid&start_ready (the accept edge), latch a, b into shift registers, carry<=cin, count<=0, go to RUN.
  - RUN: start_ready=0, busy=1. Each edge:
    - Add the low DIGIT bits of A, B and carry.
    - Shift the DIGIT sum bits into the sum register from the MSB end (after N shifts, digit 0 occupies bits DIGIT-1:0).
    - Shift A and B right by DIGIT.
    - carry<=digit carry-out; count++.
    - On the edge where count==N-1, load cout from the final digit carry and go to DONE.
  - DONE: res_valid=1, busy=1. sum and cout hold stable. When res_ready=1, go to IDLE on that edge.
- Latency:
  - res_valid is first visible exactly N edges after the accept edge.
  - One operation per N+2 cycles minimum. No overlap: start_ready=0 throughout RUN and DONE.
- Output stability:
  - sum and cout are not cleared when the result is taken.
  - They hold the last result until the next operation's shifting begins.
  - While in RUN, sum is partial and must be treated as don't-care. Only res_valid qualifies sum and cout.
- Ignored inputs:
  - Input changes on a, b, cin after the accept edge have no effect.
  - start_valid outside IDLE is ignored; it is not queued.
- Degenerate cases:
  - DIGIT==WIDTH gives N=1: one RUN cycle, and result equals a+b+cin.
  - WIDTH==1 is legal.
- Arithmetic: the result is modulo 2^WIDTH with cout as bit WIDTH. No saturation.
- Reset mid-operation: the in-flight operation is aborted, there is no res_valid pulse, and the block returns to IDLE.
- res_ready high while not in DONE has no effect.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined, adds two ports:
  - sub  in  1, sampled on the accept edge.
  - ovf  out  1, registered, cleared on reset.
- With sub=1:
  - B is bitwise inverted as it is latched.
  - Initial carry is forced to 1, ignoring cin.
  - The result is a-b mod 2^WIDTH, and cout=1 means no borrow.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (signed overflow). It is valid with res_valid, for both add and subtract.
- When not defined: sub and ovf are absent, and the block adds only.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x5A, b=0xA5, cin=1, accept at edge k -> res_valid first high after edge k+8; sum=0x00, cout=1.
- WIDTH=8, DIGIT=4: a=0xFF, b=0x01, cin=0 -> res_valid after 2 edges; sum=0x00, cout=1. Then a=0x12, b=0x34, cin=0 -> sum=0x46, cout=0.
- Backpressure: hold res_ready=0 for 5 cycles in DONE with start_valid=1 -> res_valid, sum and cout stable; start_ready=0; no second accept. Raise res_ready -> IDLE next edge, new request accepted the edge after.
- Reset mid-op: deassert rst_n during RUN cycle 3 of 8 -> immediately IDLE with all outputs 0; no res_valid. A following request a=0x01, b=0x01 -> sum=0x02.
- Sweep all 8 cin/a/b combinations at WIDTH=1 -> sum/cout match the full-adder truth table (e.g. 1,1,1 -> sum=1, cout=1).
- SERIAL_ADDER_SUB_EN, WIDTH=8: a=0x03, b=0x05, sub=1 -> sum=0xFE, cout=0, ovf=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
